// File: rtl/caliptra_axil2apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge with address window check, round-robin
// read/write arbitration, PSTRB generation and an ACCESS-phase PREADY timeout.
module caliptra_axil2apb_bridge #(
    parameter int                    AXI_ADDR_W  = 40,
    parameter int                    APB_ADDR_W  = 32,
    parameter int                    DATA_W      = 32,
    parameter logic [AXI_ADDR_W-1:0] WIN_BASE    = '0,
    parameter logic [AXI_ADDR_W-1:0] WIN_MASK    = '0,
    parameter bit                    USE_PSTRB   = 1'b1,
    parameter int                    TIMEOUT_CYC = 1024
) (
    input  logic                    core_clk,
    input  logic                    core_rst,

    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [AXI_ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    input  logic [DATA_W-1:0]       S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]     S_AXI_WSTRB,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    output logic [1:0]              S_AXI_BRESP,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    input  logic [AXI_ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [DATA_W-1:0]       S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,

    output logic [APB_ADDR_W-1:0]   PADDR,
    output logic [2:0]              PPROT,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [DATA_W-1:0]       PWDATA,
    output logic [DATA_W/8-1:0]     PSTRB,
    input  logic [DATA_W-1:0]       PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR,

    output logic [1:0]              o_dbg_state
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Valid/ready: a beat transfers on a rising edge where both are 1. Requests
    // are granted combinationally in IDLE, so every READY is a one-cycle pulse;
    // B/R VALID and their payload hold steady until the matching READY.
    state_t                 r_state, w_next_state;
    logic                   r_wr_first;
    logic [APB_ADDR_W-1:0]  r_paddr;
    logic [2:0]             r_pprot;
    logic                   r_psel, r_penable, r_pwrite;
    logic [DATA_W-1:0]      r_pwdata, r_rdata;
    logic [STRB_W-1:0]      r_pstrb;
    logic                   r_bvalid, r_rvalid;
    logic [1:0]             r_resp;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_wr_elig, w_rd_elig, w_pick_wr, w_pick_rd, w_idle;
    logic [AXI_ADDR_W-1:0]  w_req_addr;
    logic                   w_in_win, w_resp_hs, w_timeout;
    logic [CNT_W-1:0]       w_cnt_inc;

    assign w_wr_elig  = S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_elig  = S_AXI_ARVALID;
    assign w_pick_wr  = w_wr_elig & (~w_rd_elig | r_wr_first);
    assign w_pick_rd  = w_rd_elig & ~w_pick_wr;
    assign w_idle     = (r_state == ST_IDLE) & ~core_rst;
    assign w_req_addr = w_pick_wr ? S_AXI_AWADDR : S_AXI_ARADDR;
    assign w_in_win   = (w_req_addr & WIN_MASK) == WIN_BASE;
    assign w_resp_hs  = (r_bvalid & S_AXI_BREADY) | (r_rvalid & S_AXI_RREADY);
    assign w_cnt_inc  = r_cnt + 1'b1;
    // Fires on the last allowed ACCESS cycle, so exactly TIMEOUT_CYC ACCESS cycles occur.
    assign w_timeout  = (TIMEOUT_CYC != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYC));

    assign S_AXI_AWREADY = w_idle & w_pick_wr;
    assign S_AXI_WREADY  = w_idle & w_pick_wr;
    assign S_AXI_ARREADY = w_idle & w_pick_rd;

    always_ff @(posedge core_clk) begin
        if (core_rst) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_pick_wr | w_pick_rd) w_next_state = w_in_win ? ST_SETUP : ST_RESP;
            ST_SETUP:  w_next_state = ST_ACCESS;
            ST_ACCESS: if (PREADY | w_timeout) w_next_state = ST_RESP;
            ST_RESP:   if (w_resp_hs) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_wr_first <= 1'b1;
            r_paddr    <= '0;
            r_pprot    <= '0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= '0;
            r_pstrb    <= '0;
            r_rdata    <= '0;
            r_bvalid   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_resp     <= 2'b00;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_wr | w_pick_rd) begin
                        // Whoever wins, the other type is favoured next time.
                        r_wr_first <= ~w_pick_wr;
                        r_pwrite   <= w_pick_wr;
                        r_paddr    <= w_req_addr[APB_ADDR_W-1:0];
                        r_pprot    <= w_pick_wr ? S_AXI_AWPROT : S_AXI_ARPROT;
                        r_pwdata   <= w_pick_wr ? S_AXI_WDATA : '0;
                        r_pstrb    <= w_pick_wr ? (USE_PSTRB ? S_AXI_WSTRB : {STRB_W{1'b1}}) : '0;
                        r_cnt      <= '0;
                        if (w_in_win) begin
                            r_psel <= 1'b1;
                        end else begin
                            r_resp   <= 2'b10;
                            r_rdata  <= '0;
                            r_bvalid <= w_pick_wr;
                            r_rvalid <= ~w_pick_wr;
                        end
                    end
                end
                ST_SETUP: r_penable <= 1'b1;
                ST_ACCESS: begin
                    if (PREADY) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_resp    <= PSLVERR ? 2'b10 : 2'b00;
                        r_rdata   <= r_pwrite ? '0 : PRDATA;
                        r_bvalid  <= r_pwrite;
                        r_rvalid  <= ~r_pwrite;
                    end else if (w_timeout) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_resp    <= 2'b10;
                        r_rdata   <= '0;
                        r_bvalid  <= r_pwrite;
                        r_rvalid  <= ~r_pwrite;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RESP: begin
                    if (w_resp_hs) begin
                        r_bvalid <= 1'b0;
                        r_rvalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign PADDR        = r_paddr;
    assign PPROT        = r_pprot;
    assign PSEL         = r_psel;
    assign PENABLE      = r_penable;
    assign PWRITE       = r_pwrite;
    assign PWDATA       = r_pwdata;
    assign PSTRB        = r_pstrb;
    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_resp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RRESP  = r_resp;
    assign S_AXI_RDATA  = r_rdata;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_caliptra_axil2apb_bridge.sv
// Bench for caliptra_axil2apb_bridge: directed and random AXI-Lite transactions,
// a behavioural APB slave, and a response scoreboard fed by a spec-level model.
module tb_caliptra_axil2apb_bridge;
    localparam logic [39:0] WIN_BASE = 40'h0;
    localparam logic [39:0] WIN_MASK = 40'hFF_0000_0000;
    localparam int          TO       = 8;

    logic        clk, rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [39:0] awaddr, araddr;
    logic [2:0]  awprot, arprot, pprot;
    logic [31:0] wdata, rdata, pwdata, prdata;
    logic [3:0]  wstrb, pstrb;
    logic [1:0]  bresp, rresp, dbg_state;
    logic [31:0] paddr;
    logic        psel, penable, pwrite, pready, pslverr;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          m_wr_first = 1'b1;
    logic [34:0] exp_q[$];

    caliptra_axil2apb_bridge #(
        .AXI_ADDR_W(40), .APB_ADDR_W(32), .DATA_W(32),
        .WIN_BASE(WIN_BASE), .WIN_MASK(WIN_MASK),
        .USE_PSTRB(1'b1), .TIMEOUT_CYC(TO)
    ) dut (
        .core_clk(clk), .core_rst(rst),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .PADDR(paddr), .PPROT(pprot), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .o_dbg_state(dbg_state)
    );

    // clock / reset / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete transaction: AXI request, APB slave response with `waits`
    // wait states, then the B/R channel accepted after `rdy_delay` cycles.
    task automatic run_txn(input bit is_wr, input logic [39:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] prot, input int waits,
                           input bit slverr, input logic [31:0] rd_val, input int rdy_delay,
                           input bit aw_lead);
        bit          in_win, timed_out, stable, hold_ok;
        logic [1:0]  exp_resp, got_resp;
        logic [31:0] exp_rdata, got_rdata;
        logic [34:0] exp_e;
        logic [71:0] snap;
        int          exp_lat, n, k, hs_cyc;

        in_win    = (addr & WIN_MASK) == WIN_BASE;
        timed_out = in_win && (waits >= TO);
        exp_resp  = (!in_win || timed_out || slverr) ? 2'b10 : 2'b00;
        exp_rdata = (!in_win || timed_out || is_wr) ? 32'h0 : rd_val;
        exp_lat   = !in_win ? 1 : (timed_out ? 2 + TO : 3 + waits);

        @(negedge clk);
        if (is_wr) begin
            awaddr = addr; awprot = prot; wdata = data; wstrb = strb; awvalid = 1'b1;
            if (aw_lead) begin
                tick();
                check_eq("aw_alone_no_ready", {awready, wready}, 2'b00);
            end
            wvalid = 1'b1;
        end else begin
            araddr = addr; arprot = prot; arvalid = 1'b1;
        end
        #1;
        n = 0;
        while (!((is_wr && awready && wready) || (!is_wr && arready)) && n < 20) begin
            tick();
            n++;
        end
        check_eq("handshake", n < 20, 1'b1);
        if (n >= 20) begin
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            return;
        end
        exp_q.push_back({is_wr, exp_resp, exp_rdata});
        hs_cyc = cyc;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;

        if (in_win) begin
            check_eq("setup_psel_penable", {psel, penable}, 2'b10);
            check_eq("setup_paddr", paddr, addr[31:0]);
            check_eq("setup_pwrite_pprot", {pwrite, pprot}, {is_wr, prot});
            check_eq("setup_pstrb", pstrb, is_wr ? strb : 4'h0);
            if (is_wr) check_eq("setup_pwdata", pwdata, data);
            snap = {paddr, pwdata, pstrb, pprot, pwrite};
            tick();
            check_eq("access_penable", {psel, penable}, 2'b11);
            k = 0;
            stable = 1'b1;
            while (psel && k < 40) begin
                pready  = (k == waits);
                prdata  = (k == waits) ? rd_val : $urandom;
                pslverr = slverr;
                if ({paddr, pwdata, pstrb, pprot, pwrite} !== snap || !penable) stable = 1'b0;
                tick();
                k++;
            end
            pready = timed_out;  // a late PREADY after timeout must be ignored
            pslverr = 1'b0;
            check_eq("apb_stable", stable, 1'b1);
        end else begin
            check_eq("oow_no_psel", psel, 1'b0);
        end

        n = 0;
        while (!(is_wr ? bvalid : rvalid) && n < 60) begin
            tick();
            n++;
        end
        check_eq(is_wr ? "b_latency" : "r_latency", cyc - hs_cyc, exp_lat);
        got_resp  = is_wr ? bresp : rresp;
        got_rdata = rdata;
        if (timed_out) begin
            tick();
            pready = 1'b0;
        end
        hold_ok = 1'b1;
        for (int d = 0; d < rdy_delay; d++) begin
            tick();
            if (!(is_wr ? bvalid : rvalid) || (is_wr ? bresp : rresp) !== got_resp || rdata !== got_rdata)
                hold_ok = 1'b0;
        end
        check_eq("resp_hold", hold_ok, 1'b1);
        if (is_wr) bready = 1'b1; else rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        check_eq("valid_drop", {bvalid, rvalid}, 2'b00);

        exp_e = exp_q.pop_front();
        check_eq(is_wr ? "bresp" : "rresp", got_resp, exp_e[33:32]);
        if (!is_wr) check_eq("rdata", got_rdata, exp_e[31:0]);
        m_wr_first = !is_wr;
    endtask

    // Both request types held valid; grants must alternate from the favoured type.
    task automatic arb_test();
        bit grants[6];
        int ng, n;
        bit bad;
        @(negedge clk);
        awaddr = {8'h00, 32'($urandom)}; araddr = {8'h00, 32'($urandom)};
        wdata = $urandom; wstrb = 4'hF; awprot = 3'b0; arprot = 3'b0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        #1;
        ng = 0; n = 0; bad = 1'b0;
        while (ng < 6 && n < 200) begin
            pready = psel && penable;
            if (awready !== wready) bad = 1'b1;
            if (awready && arready) bad = 1'b1;
            if (awready && wready) begin grants[ng] = 1'b1; ng++; end
            else if (arready)      begin grants[ng] = 1'b0; ng++; end
            tick();
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pready = psel && penable;
            tick();
        end
        pready = 1'b0; bready = 1'b0; rready = 1'b0;
        check_eq("arb_grant_count", ng, 6);
        check_eq("arb_ready_exclusive", bad, 1'b0);
        for (int i = 0; i < ng; i++)
            check_eq($sformatf("arb_grant%0d", i), grants[i], (i % 2 == 0) ? m_wr_first : !m_wr_first);
        if (ng > 0) m_wr_first = !grants[ng-1];
    endtask

    task automatic reset_mid_access();
        int n;
        @(negedge clk);
        awaddr = 40'h00_0000_4000; awprot = 3'b0; wdata = 32'hA5A5A5A5; wstrb = 4'h3;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin tick(); n++; end
        check_eq("rst_txn_handshake", n < 20, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        tick();
        check_eq("rst_in_access", {psel, penable}, 2'b11);
        rst = 1'b1;
        tick();
        check_eq("rst_mid_outputs", {psel, penable, bvalid, rvalid}, 4'b0000);
        check_eq("rst_mid_paddr", paddr, 32'h0);
        rst = 1'b0;
        m_wr_first = 1'b1;
        tick();
        check_eq("rst_no_late_resp", {bvalid, psel}, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awaddr = 0; araddr = 0; awprot = 0; arprot = 0; wdata = 0; wstrb = 0;
        prdata = 0; pready = 0; pslverr = 0;
        repeat (3) tick();
        check_eq("reset_apb", {psel, penable, pwrite, pstrb, pprot}, 10'h0);
        check_eq("reset_paddr", paddr, 32'h0);
        check_eq("reset_axi", {bvalid, rvalid, awready, wready, arready, bresp, rresp}, 9'h0);
        rst = 1'b0;
        tick();

        run_txn(1, 40'h00_1000_0010, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 32'h0, 0, 0);
        run_txn(0, 40'h00_0000_2000, 32'h0, 4'h0, 3'b010, 3, 1, 32'h12345678, 1, 0);
        run_txn(0, 40'h01_0000_0000, 32'h0, 4'h0, 3'b001, 0, 0, 32'hCAFEF00D, 0, 0);
        run_txn(1, 40'h00_0000_0100, 32'h11223344, 4'h0, 3'b100, 1, 0, 32'h0, 2, 1);
        run_txn(1, 40'h00_0000_0200, 32'h55667788, 4'h5, 3'b011, 20, 0, 32'h0, 0, 0);
        run_txn(0, 40'h00_0000_0300, 32'h0, 4'h0, 3'b000, 7, 0, 32'h0BADBEEF, 0, 0);
        run_txn(0, 40'h00_0000_0400, 32'h0, 4'h0, 3'b000, 8, 0, 32'h0BADBEEF, 1, 0);

        for (int t = 0; t < 16; t++) begin
            logic [39:0] a;
            int          w;
            a = {($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 32'($urandom)};
            w = ($urandom_range(0, 5) == 0) ? 9 : $urandom_range(0, 4);
            run_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), w, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        arb_test();
        reset_mid_access();
        run_txn(0, 40'h00_0000_5000, 32'h0, 4'h0, 3'b000, 0, 0, 32'h600DF00D, 0, 0);
        arb_test();

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
